// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader.
// Accepts field-level RV32 instruction requests, packs each into a 32-bit word,
// and writes the words to consecutive instruction-memory addresses through a
// busywait write port. Only one request is in flight at a time.
module instr_encoder_loader #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [2:0]            REQ_FORMAT,
  input  logic [6:0]            REQ_OPCODE,
  input  logic [2:0]            REQ_FUNCT3,
  input  logic [6:0]            REQ_FUNCT7,
  input  logic [4:0]            REQ_RD,
  input  logic [4:0]            REQ_RS1,
  input  logic [4:0]            REQ_RS2,
  input  logic [31:0]           REQ_IMM,
  output logic                  IMEM_WRITE,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [31:0]           IMEM_WRITEDATA,
  input  logic                  IMEM_BUSYWAIT,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  FULL,
  output logic                  ERROR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Packs one instruction; bit 32 of the result is the legality flag.
  // Immediate ranges are checked by requiring the bits above the encodable
  // field to be a pure sign extension.
  function automatic logic [32:0] encode_word(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] word;
    logic        legal;
    word  = 32'd0;
    legal = 1'b0;
    case (fmt)
      3'd0: begin
        word  = {f7, rs2, rs1, f3, rd, op};
        legal = 1'b1;
      end
      3'd1: begin
        word  = {imm[11:0], rs1, f3, rd, op};
        legal = (imm[31:11] == {21{imm[31]}});
      end
      3'd2: begin
        word  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        legal = (imm[31:11] == {21{imm[31]}});
      end
      3'd3: begin
        word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        legal = (imm[31:12] == {20{imm[31]}}) && (imm[0] == 1'b0);
      end
      3'd4: begin
        word  = {imm[31:12], rd, op};
        legal = (imm[11:0] == 12'd0);
      end
      3'd5: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        legal = (imm[31:20] == {12{imm[31]}}) && (imm[0] == 1'b0);
      end
      default: begin
        word  = 32'd0;
        legal = 1'b0;
      end
    endcase
    return {legal, word};
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            fmt_q, fmt_d;
  logic [6:0]            op_q, op_d;
  logic [2:0]            f3_q, f3_d;
  logic [6:0]            f7_q, f7_d;
  logic [4:0]            rd_q, rd_d;
  logic [4:0]            rs1_q, rs1_d;
  logic [4:0]            rs2_q, rs2_d;
  logic [31:0]           imm_q, imm_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic                  full_s;
  logic                  ready_s;
  logic [32:0]           enc_s;

  assign full_s  = (count_q == CNT_FULL);
  assign ready_s = (state_q == ST_IDLE) && !full_s && !START;
  assign enc_s   = encode_word(fmt_q, op_q, f3_q, f7_q, rd_q, rs1_q, rs2_q, imm_q);

  // Next-state and datapath updates for the IDLE -> ENCODE -> WRITE sequence.
  always_comb begin
    state_d = state_q;
    fmt_d   = fmt_q;
    op_d    = op_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          // Clearing wins over a pending request in the same cycle.
          count_d = {(ADDR_WIDTH+1){1'b0}};
          addr_d  = BASE_ADDR;
          error_d = 1'b0;
        end else if (REQ_VALID && ready_s) begin
          fmt_d   = REQ_FORMAT;
          op_d    = REQ_OPCODE;
          f3_d    = REQ_FUNCT3;
          f7_d    = REQ_FUNCT7;
          rd_d    = REQ_RD;
          rs1_d   = REQ_RS1;
          rs2_d   = REQ_RS2;
          imm_d   = REQ_IMM;
          state_d = ST_ENCODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENCODE: begin
        if (enc_s[32]) begin
          data_d  = enc_s[31:0];
          write_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!IMEM_BUSYWAIT) begin
          write_d = 1'b0;
          count_d = count_q + CNT_ONE;
          addr_d  = addr_q + ADDR_ONE;
          state_d = ST_IDLE;
        end else begin
          write_d = 1'b1;
        end
      end
      default: begin
        write_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops an in-flight write at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      fmt_q   <= 3'd0;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      f7_q    <= 7'd0;
      rd_q    <= 5'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      imm_q   <= 32'd0;
      write_q <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'd0;
      count_q <= {(ADDR_WIDTH+1){1'b0}};
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fmt_q   <= fmt_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign REQ_READY      = ready_s;
  assign IMEM_WRITE     = write_q;
  assign IMEM_ADDR      = addr_q;
  assign IMEM_WRITEDATA = data_q;
  assign COUNT          = count_q;
  assign FULL           = full_s;
  assign ERROR          = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (small 4-word memory).
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [2:0]    REQ_FORMAT = 3'd0;
  logic [6:0]    REQ_OPCODE = 7'd0;
  logic [2:0]    REQ_FUNCT3 = 3'd0;
  logic [6:0]    REQ_FUNCT7 = 7'd0;
  logic [4:0]    REQ_RD = 5'd0;
  logic [4:0]    REQ_RS1 = 5'd0;
  logic [4:0]    REQ_RS2 = 5'd0;
  logic [31:0]   REQ_IMM = 32'd0;
  logic          IMEM_WRITE;
  logic [AW-1:0] IMEM_ADDR;
  logic [31:0]   IMEM_WRITEDATA;
  logic          IMEM_BUSYWAIT = 1'b0;
  logic [AW:0]   COUNT;
  logic          FULL;
  logic          ERROR;

  int checks_cnt = 0;
  int errors_cnt = 0;

  int          last_wr;
  logic [31:0] last_data;
  logic [31:0] last_addr;
  logic        last_stable;
  logic        last_rdy;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(2'd0)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_FORMAT(REQ_FORMAT), .REQ_OPCODE(REQ_OPCODE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_FUNCT7(REQ_FUNCT7),
    .REQ_RD(REQ_RD), .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_IMM(REQ_IMM),
    .IMEM_WRITE(IMEM_WRITE), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_WRITEDATA(IMEM_WRITEDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .COUNT(COUNT), .FULL(FULL), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch the following cycles for the write it produces.
  task automatic run_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input int busy);
    last_wr = 0; last_data = 32'd0; last_addr = 32'd0; last_stable = 1'b1; last_rdy = 1'b0;
    @(negedge CLK);
    IMEM_BUSYWAIT = (busy > 0);
    REQ_FORMAT = fmt; REQ_OPCODE = op; REQ_FUNCT3 = f3; REQ_FUNCT7 = f7;
    REQ_RD = rd; REQ_RS1 = rs1; REQ_RS2 = rs2; REQ_IMM = imm;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (IMEM_WRITE) begin
        if (last_wr == 0) begin
          last_data = IMEM_WRITEDATA;
          last_addr = 32'(IMEM_ADDR);
        end else if (last_data !== IMEM_WRITEDATA || last_addr !== 32'(IMEM_ADDR)) begin
          last_stable = 1'b0;
        end
        if (REQ_READY) last_rdy = 1'b1;
        last_wr++;
        if (last_wr > busy) IMEM_BUSYWAIT = 1'b0;
      end
    end
    IMEM_BUSYWAIT = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    #1 check_val("ready_during_start", 32'(REQ_READY), 32'd0);
    @(negedge CLK);
    START = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check_val("rst_write", 32'(IMEM_WRITE), 32'd0);
    check_val("rst_addr", 32'(IMEM_ADDR), 32'd0);
    check_val("rst_data", IMEM_WRITEDATA, 32'd0);
    check_val("rst_count", 32'(COUNT), 32'd0);
    check_val("rst_error", 32'(ERROR), 32'd0);
    RESET = 1'b0;
    #1 check_val("rst_ready", 32'(REQ_READY), 32'd1);

    // Fill the 4-word memory
    run_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0);
    check_val("addi_data", last_data, 32'h0050_0093);
    check_val("addi_addr", last_addr, 32'd0);
    check_val("addi_wrcyc", 32'(last_wr), 32'd1);
    check_val("addi_count", 32'(COUNT), 32'd1);
    run_req(3'd0, 7'b0110011, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    check_val("sub_data", last_data, 32'h4020_81B3);
    check_val("sub_addr", last_addr, 32'd1);
    run_req(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0);
    check_val("sw_data", last_data, 32'h0020_A423);
    check_val("sw_addr", last_addr, 32'd2);
    run_req(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 0);
    check_val("beq_data", last_data, 32'hFE20_8EE3);
    check_val("beq_addr", last_addr, 32'd3);
    check_val("full_count", 32'(COUNT), 32'd4);
    check_val("full_flag", 32'(FULL), 32'd1);
    check_val("full_ready", 32'(REQ_READY), 32'd0);
    check_val("full_wrap_addr", 32'(IMEM_ADDR), 32'd0);

    // START clears the counters
    pulse_start();
    check_val("start_count", 32'(COUNT), 32'd0);
    check_val("start_full", 32'(FULL), 32'd0);
    check_val("start_ready", 32'(REQ_READY), 32'd1);

    run_req(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 0);
    check_val("jal_data", last_data, 32'h0080_00EF);
    check_val("jal_addr", last_addr, 32'd0);
    run_req(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 0);
    check_val("lui_data", last_data, 32'h1234_52B7);
    check_val("lui_addr", last_addr, 32'd1);
    check_val("lui_count", 32'(COUNT), 32'd2);

    // Illegal requests: flagged, no write, count unchanged
    run_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 0);
    check_val("ibad_wrcyc", 32'(last_wr), 32'd0);
    check_val("ibad_error", 32'(ERROR), 32'd1);
    check_val("ibad_count", 32'(COUNT), 32'd2);
    run_req(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 0);
    check_val("bbad_wrcyc", 32'(last_wr), 32'd0);
    check_val("bbad_count", 32'(COUNT), 32'd2);
    run_req(3'd7, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 0);
    check_val("fmt7_wrcyc", 32'(last_wr), 32'd0);

    // Legal request after an error is still written; error stays set
    run_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF, 0);
    check_val("neg_data", last_data, 32'hFFF0_8093);
    check_val("neg_addr", last_addr, 32'd2);
    check_val("neg_count", 32'(COUNT), 32'd3);
    check_val("neg_error", 32'(ERROR), 32'd1);

    pulse_start();
    check_val("start_err_clr", 32'(ERROR), 32'd0);
    check_val("start_addr", 32'(IMEM_ADDR), 32'd0);

    // Busywait held for 4 cycles
    run_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 4);
    check_val("busy_data", last_data, 32'h7FF0_0093);
    check_val("busy_wrcyc", 32'(last_wr), 32'd5);
    check_val("busy_stable", 32'(last_stable), 32'd1);
    check_val("busy_ready", 32'(last_rdy), 32'd0);
    check_val("busy_count", 32'(COUNT), 32'd1);

    // Immediate boundaries
    run_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 0);
    check_val("imin_data", last_data, 32'h8000_0093);
    check_val("imin_addr", last_addr, 32'd1);
    run_req(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 0);
    check_val("ubad_wrcyc", 32'(last_wr), 32'd0);
    check_val("ubad_error", 32'(ERROR), 32'd1);
    run_req(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 0);
    check_val("jmin_data", last_data, 32'h8000_006F);
    check_val("jmin_count", 32'(COUNT), 32'd3);

    // Reset while a write is stalled
    @(negedge CLK);
    IMEM_BUSYWAIT = 1'b1;
    REQ_FORMAT = 3'd1; REQ_OPCODE = 7'b0010011; REQ_FUNCT3 = 3'd0;
    REQ_RD = 5'd1; REQ_RS1 = 5'd0; REQ_IMM = 32'd5;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    check_val("mid_write_hi", 32'(IMEM_WRITE), 32'd1);
    #1 RESET = 1'b1;
    #1;
    check_val("mid_rst_write", 32'(IMEM_WRITE), 32'd0);
    check_val("mid_rst_count", 32'(COUNT), 32'd0);
    check_val("mid_rst_error", 32'(ERROR), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    check_val("mid_rst_ready", 32'(REQ_READY), 32'd1);
    run_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0);
    check_val("post_rst_addr", last_addr, 32'd0);
    check_val("post_rst_count", 32'(COUNT), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
